mdu_hilo: RTL and testbench

- Multiply/divide unit with HI/LO registers for the CPU pipeline.
- Sits in E stage beside the ALU.
- Acts as responder to the E-stage controller: the controller issues mult/div/mthi/mtlo requests; this block returns Busy, which the D-stage hazard logic uses to stall.
- Models fixed multi-cycle latency so stall/forward logic can be exercised against real timing.

---
 rtl/mdu_hilo.sv | 133 +++++++++++++
 tb/tb_mdu_hilo.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/mdu_hilo.sv
// Multiply/divide unit with HI/LO registers.
// The result is computed when Start is accepted and parked in a pending
// register; Busy is then held for a fixed number of cycles so the stall and
// forward logic sees real multi-cycle timing. HI/LO update on the edge that
// drops Busy.
module mdu_hilo #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Start,
    input  logic [1:0]  MDOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        WE_HI,
    input  logic        WE_LO,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [CNT_W-1:0] MULT_N  = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_N   = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // MDOp[1] selects divide, MDOp[0] selects the unsigned flavour.
    logic             busy;
    logic [CNT_W-1:0] cnt;
    logic             pend_wr;
    logic [63:0]      pend;
    logic [31:0]      hi;
    logic [31:0]      lo;

    logic             calc_wr;
    logic [63:0]      calc_res;

    // Full 64-bit {HI, LO} result for one operation, plus a flag that is
    // cleared for divide-by-zero so HI/LO keep their old contents.
    // Signed divide runs at 33 bits so 0x80000000 / -1 yields +2^31, whose
    // low word is the architecturally expected 0x80000000 with remainder 0.
    function automatic logic [64:0] mdu_calc(
        input logic [1:0]  op,
        input logic [31:0] a,
        input logic [31:0] b
    );
        logic signed [63:0] sa64;
        logic signed [63:0] sb64;
        logic signed [32:0] sa33;
        logic signed [32:0] sb33;
        logic        [63:0] res;
        logic               wr;
        sa64 = {{32{a[31]}}, a};
        sb64 = {{32{b[31]}}, b};
        sa33 = {a[31], a};
        sb33 = {b[31], b};
        res  = 64'd0;
        wr   = 1'b1;
        case (op)
            2'b00: res = sa64 * sb64;
            2'b01: res = {32'd0, a} * {32'd0, b};
            2'b10: begin
                if (b == 32'd0) begin
                    wr = 1'b0;
                end else begin
                    res[31:0]  = 32'(sa33 / sb33);
                    res[63:32] = 32'(sa33 % sb33);
                end
            end
            default: begin
                if (b == 32'd0) begin
                    wr = 1'b0;
                end else begin
                    res[31:0]  = a / b;
                    res[63:32] = a % b;
                end
            end
        endcase
        return {wr, res};
    endfunction

    assign {calc_wr, calc_res} = mdu_calc(MDOp, A, B);

    // Control: Busy, cycle counter and the pending-write flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy    <= 1'b0;
            cnt     <= '0;
            pend_wr <= 1'b0;
        end else if (busy) begin
            cnt <= cnt - CNT_ONE;
            if (cnt == CNT_ONE) begin
                busy    <= 1'b0;
                pend_wr <= 1'b0;
            end
        end else if (Start) begin
            busy    <= 1'b1;
            cnt     <= MDOp[1] ? DIV_N : MULT_N;
            pend_wr <= calc_wr;
        end
    end

    // Pending result captured from the operands present at Start.
    always_ff @(posedge clk) begin
        if (!busy && Start) begin
            pend <= calc_res;
        end
    end

    // HI/LO: completion write has priority; mthi/mtlo only when fully idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            hi <= 32'd0;
            lo <= 32'd0;
        end else if (busy) begin
            if (cnt == CNT_ONE && pend_wr) begin
                hi <= pend[63:32];
                lo <= pend[31:0];
            end
        end else if (!Start) begin
            if (WE_HI) hi <= A;
            if (WE_LO) lo <= A;
        end
    end

    assign Busy = busy;
    assign HI   = hi;
    assign LO   = lo;

endmodule

// File: tb/tb_mdu_hilo.sv
// Self-checking bench for mdu_hilo: directed scenarios followed by random
// traffic, all compared against a cycle-level arithmetic reference model.
module tb_mdu_hilo;

    localparam int MULT_CYCLES = 5;
    localparam int DIV_CYCLES  = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        Start;
    logic [1:0]  MDOp;
    logic [31:0] A;
    logic [31:0] B;
    logic        WE_HI;
    logic        WE_LO;
    logic        Busy;
    logic [31:0] HI;
    logic [31:0] LO;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    int          m_left = 0;
    logic        m_wr   = 1'b0;
    logic [31:0] m_phi  = 32'd0;
    logic [31:0] m_plo  = 32'd0;
    logic [31:0] m_hi   = 32'd0;
    logic [31:0] m_lo   = 32'd0;

    mdu_hilo #(
        .MULT_CYCLES(MULT_CYCLES),
        .DIV_CYCLES (DIV_CYCLES)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .Start(Start),
        .MDOp (MDOp),
        .A    (A),
        .B    (B),
        .WE_HI(WE_HI),
        .WE_LO(WE_LO),
        .Busy (Busy),
        .HI   (HI),
        .LO   (LO)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Architectural result of one operation using plain 64-bit arithmetic.
    function automatic void ref_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                   output logic wr, output logic [31:0] rh, output logic [31:0] rl);
        int                sa;
        int                sb;
        longint            ls;
        longint            lb;
        longint            p;
        longint unsigned   ua;
        longint unsigned   ub;
        longint unsigned   pu;
        sa = a;
        sb = b;
        ls = sa;
        lb = sb;
        ua = {32'd0, a};
        ub = {32'd0, b};
        wr = 1'b1;
        rh = 32'd0;
        rl = 32'd0;
        case (op)
            2'd0: begin p = ls * lb; rh = p[63:32]; rl = p[31:0]; end
            2'd1: begin pu = ua * ub; rh = pu[63:32]; rl = pu[31:0]; end
            2'd2: begin
                if (b == 0) wr = 1'b0;
                else begin p = ls / lb; rl = p[31:0]; p = ls % lb; rh = p[31:0]; end
            end
            default: begin
                if (b == 0) wr = 1'b0;
                else begin pu = ua / ub; rl = pu[31:0]; pu = ua % ub; rh = pu[31:0]; end
            end
        endcase
    endfunction

    // Drive one cycle of inputs, advance the model across the edge, check.
    task automatic cycle(input logic st, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic wh, input logic wl, input logic rs);
        logic        wr;
        logic [31:0] rh;
        logic [31:0] rl;
        reset = rs; Start = st; MDOp = op; A = a; B = b; WE_HI = wh; WE_LO = wl;
        @(posedge clk);
        if (rs) begin
            m_left = 0; m_hi = 0; m_lo = 0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0 && m_wr) begin m_hi = m_phi; m_lo = m_plo; end
        end else if (st) begin
            ref_op(op, a, b, wr, rh, rl);
            m_wr = wr; m_phi = rh; m_plo = rl;
            m_left = op[1] ? DIV_CYCLES : MULT_CYCLES;
        end else begin
            if (wh) m_hi = a;
            if (wl) m_lo = a;
        end
        #1;
        check("busy", {31'd0, Busy}, {31'd0, (m_left > 0)});
        check("hi", HI, m_hi);
        check("lo", LO, m_lo);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 2'($urandom), $urandom, $urandom, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        cycle(1'b1, o, a, b, 1'b0, 1'b0, 1'b0);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 6))
            0: return 32'd0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'd1;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        reset = 1'b1; Start = 1'b0; MDOp = 2'd0; A = 32'd0; B = 32'd0; WE_HI = 1'b0; WE_LO = 1'b0;
        cycle(1'b0, 2'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 2'd0, 32'd5, 32'd5, 1'b1, 1'b1, 1'b1);
        check("reset_hi", HI, 32'd0);

        // MULT -2 * 3
        op(2'd0, 32'hFFFF_FFFE, 32'd3);
        idle(MULT_CYCLES);
        check("mult_hi", HI, 32'hFFFF_FFFF);
        check("mult_lo", LO, 32'hFFFF_FFFA);

        // MULTU 0xFFFFFFFF * 2, operands change during Busy (idle randomizes them)
        op(2'd1, 32'hFFFF_FFFF, 32'd2);
        idle(MULT_CYCLES);
        check("multu_hi", HI, 32'h0000_0001);
        check("multu_lo", LO, 32'hFFFF_FFFE);

        // DIV -7 / 2
        op(2'd2, 32'hFFFF_FFF9, 32'd2);
        idle(DIV_CYCLES);
        check("div_lo", LO, 32'hFFFF_FFFD);
        check("div_hi", HI, 32'hFFFF_FFFF);

        // DIVU 7 / 0 leaves HI/LO alone
        op(2'd3, 32'd7, 32'd0);
        idle(DIV_CYCLES);
        check("divz_lo", LO, 32'hFFFF_FFFD);
        check("divz_hi", HI, 32'hFFFF_FFFF);

        // mthi, then writes and a second Start while Busy are ignored
        cycle(1'b0, 2'd0, 32'h1234_5678, 32'd0, 1'b1, 1'b0, 1'b0);
        check("mthi", HI, 32'h1234_5678);
        op(2'd0, 32'd3, 32'd4);
        cycle(1'b0, 2'd0, 32'hDEAD_BEEF, 32'd0, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 2'd2, 32'd100, 32'd7, 1'b1, 1'b0, 1'b0);
        idle(MULT_CYCLES - 2);
        check("busy_ign_lo", LO, 32'd12);
        check("busy_ign_hi", HI, 32'd0);

        // signed overflow divide
        op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        idle(DIV_CYCLES);
        check("ovf_lo", LO, 32'h8000_0000);
        check("ovf_hi", HI, 32'd0);

        // Start beats simultaneous mthi/mtlo
        cycle(1'b1, 2'd1, 32'd6, 32'd7, 1'b1, 1'b1, 1'b0);
        idle(MULT_CYCLES);
        check("start_wins_lo", LO, 32'd42);

        // reset during a divide discards it
        op(2'd3, 32'd1000, 32'd3);
        idle(3);
        cycle(1'b0, 2'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
        idle(DIV_CYCLES + 2);
        check("rst_mid_hi", HI, 32'd0);
        check("rst_mid_lo", LO, 32'd0);

        // back-to-back: second op issued the cycle after Busy falls
        op(2'd0, 32'd10, 32'd10);
        idle(MULT_CYCLES);
        op(2'd1, 32'h0001_0000, 32'h0001_0000);
        idle(MULT_CYCLES);
        check("b2b_hi", HI, 32'd1);
        check("b2b_lo", LO, 32'd0);

        // random traffic
        for (int i = 0; i < 1500; i++) begin
            cycle(($urandom_range(0, 3) == 0), 2'($urandom), pick(), pick(),
                  ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 150) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
